adc_sample_avg: RTL and testbench

ADC_SAMPLE_AVG -- requirements
Module: adc_sample_avg

---
 rtl/adc_sample_avg_pkg.sv | 23 ++
 rtl/adc_sample_avg_timeout.sv | 36 +++
 rtl/adc_sample_avg.sv | 152 +++++++++++++++
 tb/tb_adc_sample_avg.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/adc_sample_avg_pkg.sv
// Shared definitions for the ADC sample averager: FSM encodings, the default
// code width and the accumulator width rule. Imported by the RTL and the bench.
package adc_sample_avg_pkg;

    // Default converter code width
    localparam int CADC_WIDTH_DEF = 10;

    // Extra accumulator bits: up to 8 samples are summed, so 3 guard bits
    // keep 8 * (2^W - 1) from overflowing.
    localparam int ACC_EXTRA = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_ACQ   = 2'd2,
        ST_DONE  = 2'd3
    } avg_state_e;

    function automatic int acc_width(input int code_w);
        return code_w + ACC_EXTRA;
    endfunction

endpackage

// File: rtl/adc_sample_avg_timeout.sv
// Inter-sample watchdog for the averager. Counts enabled cycles since the last
// clear and saturates at LIMIT; expired is high while the count sits at LIMIT.
module adc_timeout_cnt #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign expired = (cnt_q == CW'(LIMIT));

    // Clear wins over enable; hold at the limit so the count never wraps
    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (en && !expired)
            cnt_d = cnt_q + CW'(1);
    end

    // Counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/adc_sample_avg.sv
// ADC sample averager: on START collects 2^AVG_LOG2 converter samples, sums
// them and publishes sum >> AVG_LOG2 with a ready flag. An acquisition that
// starves for TIMEOUT_CYCLES cycles is abandoned and flagged on TIMEOUT.
// Build option: define ADC_AVG_ROUND_EN to round-half-up the average
// (with saturation) instead of truncating.
module adc_sample_avg
    import adc_sample_avg_pkg::*;
#(
    parameter int CADC_WIDTH     = CADC_WIDTH_DEF,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic [1:0]            AVG_LOG2,
    input  logic [CADC_WIDTH-1:0] ADC_DIN,
    input  logic                  ADC_VALID,
    output logic [CADC_WIDTH-1:0] ADC_OUT,
    output logic                  ADC_RDY,
    output logic                  BUSY,
    output logic                  TIMEOUT
);

    localparam int ACC_W = acc_width(CADC_WIDTH);

    avg_state_e            state_q, state_d;
    logic [1:0]            avg_q, avg_d;
    logic [ACC_W-1:0]      acc_q, acc_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [CADC_WIDTH-1:0] out_q, out_d;
    logic                  rdy_q, rdy_d;
    logic                  busy_q, busy_d;
    logic                  tout_q, tout_d;

    logic                  tmo_clr, tmo_en, tmo_exp;
    logic [3:0]            n_target;
    logic [CADC_WIDTH-1:0] avg_res;

    assign n_target = 4'd1 << avg_q;

`ifdef ADC_AVG_ROUND_EN
    logic [ACC_W:0] rnd_sum, rnd_shr;

    // Round half up by adding half an LSB of the result, then clamp to full scale
    always_comb begin
        rnd_sum = {1'b0, acc_q};
        if (avg_q != 2'd0)
            rnd_sum = rnd_sum + ((ACC_W + 1)'(1) << (avg_q - 2'd1));
        rnd_shr = rnd_sum >> avg_q;
        avg_res = (|rnd_shr[ACC_W:CADC_WIDTH]) ? '1 : rnd_shr[CADC_WIDTH-1:0];
    end
`else
    // Plain truncating average; the sum of 2^n codes divided by 2^n always fits
    always_comb begin
        avg_res = CADC_WIDTH'(acc_q >> avg_q);
    end
`endif

    adc_timeout_cnt #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_tmo (
        .clk     (CLK),
        .rst     (RST),
        .clr     (tmo_clr),
        .en      (tmo_en),
        .expired (tmo_exp)
    );

    // Next-state and next-output logic; START and ADC_VALID only matter in IDLE/ACQ
    always_comb begin
        state_d = state_q;
        avg_d   = avg_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        rdy_d   = rdy_q;
        busy_d  = busy_q;
        tout_d  = tout_q;
        tmo_clr = 1'b0;
        tmo_en  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    state_d = ST_CLEAR;
                    avg_d   = AVG_LOG2;
                    rdy_d   = 1'b0;
                    tout_d  = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            ST_CLEAR: begin
                acc_d   = '0;
                cnt_d   = '0;
                tmo_clr = 1'b1;
                state_d = ST_ACQ;
            end
            ST_ACQ: begin
                // A sample arriving on the expiry cycle still counts
                if (ADC_VALID) begin
                    acc_d   = acc_q + ACC_W'(ADC_DIN);
                    cnt_d   = cnt_q + 4'd1;
                    tmo_clr = 1'b1;
                    if (cnt_q + 4'd1 == n_target)
                        state_d = ST_DONE;
                end else if (tmo_exp) begin
                    state_d = ST_IDLE;
                    tout_d  = 1'b1;
                    rdy_d   = 1'b0;
                    busy_d  = 1'b0;
                end else begin
                    tmo_en = 1'b1;
                end
            end
            ST_DONE: begin
                out_d   = avg_res;
                rdy_d   = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and registered outputs; reset discards any partial sum
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            avg_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            rdy_q   <= 1'b0;
            busy_q  <= 1'b0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            avg_q   <= avg_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            rdy_q   <= rdy_d;
            busy_q  <= busy_d;
            tout_q  <= tout_d;
        end
    end

    assign ADC_OUT = out_q;
    assign ADC_RDY = rdy_q;
    assign BUSY    = busy_q;
    assign TIMEOUT = tout_q;

endmodule

// File: tb/tb_adc_sample_avg.sv
// Directed bench for adc_sample_avg: single sample, 4- and 8-sample averages,
// timeout with sample precedence, ignored START/ADC_VALID, mid-run reset.
module tb_adc_sample_avg;
    import adc_sample_avg_pkg::*;

    localparam int W = CADC_WIDTH_DEF;

    logic         CLK;
    logic         RST;
    logic         START;
    logic [1:0]   AVG_LOG2;
    logic [W-1:0] ADC_DIN;
    logic         ADC_VALID;
    logic [W-1:0] ADC_OUT;
    logic         ADC_RDY;
    logic         BUSY;
    logic         TIMEOUT;

    int           checks;
    int           errors;
    logic [W-1:0] exp_v;

    adc_sample_avg #(
        .CADC_WIDTH     (W),
        .TIMEOUT_CYCLES (255)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .START     (START),
        .AVG_LOG2  (AVG_LOG2),
        .ADC_DIN   (ADC_DIN),
        .ADC_VALID (ADC_VALID),
        .ADC_OUT   (ADC_OUT),
        .ADC_RDY   (ADC_RDY),
        .BUSY      (BUSY),
        .TIMEOUT   (TIMEOUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Called at a negedge; returns at the negedge of the first ACQ cycle
    task automatic drive_start(input logic [1:0] a);
        START = 1'b1; AVG_LOG2 = a;
        @(negedge CLK);
        START = 1'b0;
        @(negedge CLK);
    endtask

    // One-cycle sample; returns at the following negedge
    task automatic drive_sample(input logic [W-1:0] d);
        ADC_VALID = 1'b1; ADC_DIN = d;
        @(negedge CLK);
        ADC_VALID = 1'b0;
    endtask

    task automatic test_reset;
        RST = 1'b0;
        #2 RST = 1'b1;
        repeat (2) @(negedge CLK);
        checks++; if (ADC_OUT !== '0) begin errors++; $display("FAIL rst_out: got %0d want 0", ADC_OUT); end
        checks++; if (ADC_RDY !== 1'b0) begin errors++; $display("FAIL rst_rdy: got %0b want 0", ADC_RDY); end
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0b want 0", BUSY); end
        checks++; if (TIMEOUT !== 1'b0) begin errors++; $display("FAIL rst_timeout: got %0b want 0", TIMEOUT); end
        RST = 1'b0;
    endtask

    task automatic test_single;
        drive_start(2'd0);
        checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL single_busy_acq: got %0b want 1", BUSY); end
        drive_sample(10'h1FF);
        checks++; if (ADC_RDY !== 1'b0) begin errors++; $display("FAIL single_rdy_k1: got %0b want 0", ADC_RDY); end
        @(negedge CLK);
        checks++; if (ADC_RDY !== 1'b1) begin errors++; $display("FAIL single_rdy_k2: got %0b want 1", ADC_RDY); end
        checks++; if (ADC_OUT !== 10'h1FF) begin errors++; $display("FAIL single_out: got %0h want 1ff", ADC_OUT); end
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL single_busy_done: got %0b want 0", BUSY); end
    endtask

    task automatic test_avg4;
        drive_start(2'd2);
        checks++; if (ADC_RDY !== 1'b0) begin errors++; $display("FAIL avg4_rdy_cleared: got %0b want 0", ADC_RDY); end
        checks++; if (ADC_OUT !== 10'h1FF) begin errors++; $display("FAIL avg4_out_held: got %0h want 1ff", ADC_OUT); end
        drive_sample(10'd100);
        drive_sample(10'd101);
        drive_sample(10'd102);
        drive_sample(10'd104);
        @(negedge CLK);
`ifdef ADC_AVG_ROUND_EN
        exp_v = 10'd102;
`else
        exp_v = 10'd101;
`endif
        checks++; if (ADC_OUT !== exp_v) begin errors++; $display("FAIL avg4_out: got %0d want %0d", ADC_OUT, exp_v); end
        repeat (3) @(negedge CLK);
        checks++; if (ADC_RDY !== 1'b1 || ADC_OUT !== exp_v) begin errors++; $display("FAIL avg4_hold: got rdy %0b out %0d want rdy 1 out %0d", ADC_RDY, ADC_OUT, exp_v); end
    endtask

    task automatic test_overflow;
        drive_start(2'd3);
        for (int i = 0; i < 8; i++) drive_sample(10'd1023);
        @(negedge CLK);
        checks++; if (ADC_OUT !== 10'd1023) begin errors++; $display("FAIL ovf_out: got %0d want 1023", ADC_OUT); end
        checks++; if (ADC_RDY !== 1'b1) begin errors++; $display("FAIL ovf_rdy: got %0b want 1", ADC_RDY); end
    endtask

    task automatic test_timeout_precedence;
        drive_start(2'd1);
        drive_sample(10'd20);
        repeat (255) @(negedge CLK);
        // Watchdog is at its limit this cycle; the sample must win
        drive_sample(10'd30);
        checks++; if (TIMEOUT !== 1'b0 || BUSY !== 1'b1) begin errors++; $display("FAIL prec_state: got to %0b busy %0b want to 0 busy 1", TIMEOUT, BUSY); end
        @(negedge CLK);
        checks++; if (ADC_RDY !== 1'b1 || ADC_OUT !== 10'd25) begin errors++; $display("FAIL prec_out: got rdy %0b out %0d want rdy 1 out 25", ADC_RDY, ADC_OUT); end
    endtask

    task automatic test_timeout;
        drive_start(2'd1);
        drive_sample(10'd7);
        repeat (255) @(negedge CLK);
        checks++; if (TIMEOUT !== 1'b0 || BUSY !== 1'b1) begin errors++; $display("FAIL tmo_early: got to %0b busy %0b want to 0 busy 1", TIMEOUT, BUSY); end
        @(negedge CLK);
        checks++; if (TIMEOUT !== 1'b1) begin errors++; $display("FAIL tmo_flag: got %0b want 1", TIMEOUT); end
        checks++; if (ADC_RDY !== 1'b0 || BUSY !== 1'b0) begin errors++; $display("FAIL tmo_rdy_busy: got rdy %0b busy %0b want 0 0", ADC_RDY, BUSY); end
        checks++; if (ADC_OUT !== 10'd25) begin errors++; $display("FAIL tmo_out_kept: got %0d want 25", ADC_OUT); end
    endtask

    task automatic test_ignore;
        // ADC_VALID in IDLE
        for (int i = 0; i < 3; i++) drive_sample(10'd999);
        checks++; if (BUSY !== 1'b0 || TIMEOUT !== 1'b1 || ADC_OUT !== 10'd25) begin errors++; $display("FAIL ign_idle: got busy %0b to %0b out %0d want 0 1 25", BUSY, TIMEOUT, ADC_OUT); end
        // START, then ADC_VALID during CLEAR
        START = 1'b1; AVG_LOG2 = 2'd1;
        @(negedge CLK);
        START = 1'b0; ADC_VALID = 1'b1; ADC_DIN = 10'd500;
        @(negedge CLK);
        ADC_VALID = 1'b0;
        checks++; if (TIMEOUT !== 1'b0 || BUSY !== 1'b1) begin errors++; $display("FAIL ign_start_clear: got to %0b busy %0b want 0 1", TIMEOUT, BUSY); end
        drive_sample(10'd40);
        // Stray START with a different AVG_LOG2 during ACQ
        START = 1'b1; AVG_LOG2 = 2'd3;
        @(negedge CLK);
        START = 1'b0;
        // Last sample, then keep ADC_VALID high through DONE
        ADC_VALID = 1'b1; ADC_DIN = 10'd60;
        @(negedge CLK);
        ADC_DIN = 10'd900;
        @(negedge CLK);
        ADC_VALID = 1'b0;
        checks++; if (ADC_RDY !== 1'b1 || ADC_OUT !== 10'd50) begin errors++; $display("FAIL ign_result: got rdy %0b out %0d want rdy 1 out 50", ADC_RDY, ADC_OUT); end
        @(negedge CLK);
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL ign_no_restart: got busy %0b want 0", BUSY); end
    endtask

    task automatic test_reset_mid;
        drive_start(2'd2);
        drive_sample(10'd300);
        drive_sample(10'd300);
        RST = 1'b1;
        #1;
        checks++; if (ADC_OUT !== '0 || ADC_RDY !== 1'b0 || BUSY !== 1'b0 || TIMEOUT !== 1'b0) begin errors++; $display("FAIL midrst_outs: got out %0d rdy %0b busy %0b to %0b want all 0", ADC_OUT, ADC_RDY, BUSY, TIMEOUT); end
        @(negedge CLK);
        RST = 1'b0;
        drive_sample(10'd8);
        drive_sample(10'd8);
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL midrst_wait: got busy %0b want 0", BUSY); end
        drive_start(2'd2);
        for (int i = 0; i < 4; i++) drive_sample(10'd8);
        @(negedge CLK);
        checks++; if (ADC_RDY !== 1'b1 || ADC_OUT !== 10'd8) begin errors++; $display("FAIL midrst_result: got rdy %0b out %0d want rdy 1 out 8", ADC_RDY, ADC_OUT); end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        RST       = 1'b0;
        START     = 1'b0;
        AVG_LOG2  = 2'd0;
        ADC_DIN   = '0;
        ADC_VALID = 1'b0;
        test_reset();
        test_single();
        test_avg4();
        test_overflow();
        test_timeout_precedence();
        test_timeout();
        test_ignore();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
